// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encoding, word size
// and the default load address (the same reset vector the CPU PC starts from).
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_HI  = 3'd0,
        S_LEN_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    localparam int          WORD_BYTES        = 2;
    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0000;

endpackage

// File: rtl/program_loader.sv
// Boot loader: assembles a length-prefixed big-endian byte stream into 16-bit words,
// writes them to memory at consecutive even addresses, then releases the CPU from reset.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_LEN_HI  | waiting for image length, high byte
//  S_LEN_LO  | waiting for image length, low byte; length checked here
//  S_DATA_HI | waiting for high byte of the next word
//  S_DATA_LO | waiting for low byte of the next word
//  S_WRITE   | one-cycle memory write strobe, no byte accepted
//  S_DONE    | image complete, CPU released (terminal)
//  S_ERR     | length rejected, CPU stays held (terminal)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int          CNT_W   = $clog2(MAX_WORDS + 1);
    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [15:0]         len_rx;
    logic                xfer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LEN_HI;
            cnt_q   <= '0;
            len_q   <= '0;
            hi_q    <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        len_rx  = {hi_q, in_data};
        xfer    = in_valid && in_ready;

        case (state_q)
            S_LEN_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_rx;
                    if (len_rx == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, len_rx} > MAX_LEN) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                // Address and data are latched here so S_WRITE drives pure registers.
                if (xfer) begin
                    wdata_d = DATA_W'({hi_q, in_data});
                    addr_d  = BASE_ADDR + ADDR_W'(cnt_q) * ADDR_W'(WORD_BYTES);
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if ((16'(cnt_q) + 16'd1) == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA_HI;
                end
            end
            default: state_d = state_q;
        endcase
    end

    assign in_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                       (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
    assign mem_write = (state_q == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst_n = (state_q == S_DONE);
    assign done      = cpu_rst_n;
    assign busy      = !((state_q == S_DONE) || (state_q == S_ERR));
    assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: two loaders (base 0x0000 and 0xFFFE) share one randomized
// byte stream; observed memory writes and status are checked against an image model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        a_in_ready, a_mem_write, a_cpu_rst_n, a_busy, a_done, a_err;
    logic [15:0] a_mem_addr, a_mem_wdata;
    logic        b_in_ready, b_mem_write, b_cpu_rst_n, b_busy, b_done, b_err;
    logic [15:0] b_mem_addr, b_mem_wdata;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [31:0] wr_a[$], wr_b[$], exp_a[$], exp_b[$];
    logic [7:0]  stream[$];

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(16'h0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .cpu_rst_n(a_cpu_rst_n), .busy(a_busy),
        .done(a_done), .err(a_err)
    );

    program_loader #(.BASE_ADDR(16'hFFFE)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .cpu_rst_n(b_cpu_rst_n), .busy(b_busy),
        .done(b_done), .err(b_err)
    );

    // Memory model: capture every strobe mid-cycle.
    always @(negedge clk) begin
        if (a_mem_write) wr_a.push_back({a_mem_addr, a_mem_wdata});
        if (b_mem_write) wr_b.push_back({b_mem_addr, b_mem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic dn, input logic er,
                                input logic bz, input logic rdy);
        chk({tag, "_a_done"},  32'(a_done), 32'(dn));
        chk({tag, "_a_cpurst"}, 32'(a_cpu_rst_n), 32'(dn));
        chk({tag, "_a_err"},   32'(a_err), 32'(er));
        chk({tag, "_a_busy"},  32'(a_busy), 32'(bz));
        chk({tag, "_a_ready"}, 32'(a_in_ready), 32'(rdy));
        chk({tag, "_b_done"},  32'(b_done), 32'(dn));
        chk({tag, "_b_err"},   32'(b_err), 32'(er));
        chk({tag, "_b_ready"}, 32'(b_in_ready), 32'(rdy));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_status({tag, "_rst"}, 1'b0, 1'b0, 1'b1, 1'b1);
        chk({tag, "_rst_a_wr"},    32'(a_mem_write), 32'd0);
        chk({tag, "_rst_a_addr"},  32'(a_mem_addr), 32'h0000);
        chk({tag, "_rst_a_wdata"}, 32'(a_mem_wdata), 32'h0000);
        chk({tag, "_rst_b_addr"},  32'(b_mem_addr), 32'hFFFE);
        rst_n = 1'b1;
    endtask

    task automatic clear_queues();
        wr_a.delete(); wr_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    // Offer each stream byte until a handshake occurs; idle cycles carry junk data.
    task automatic send_stream(input int idle_pct, input string tag);
        foreach (stream[i]) begin
            bit   taken = 1'b0;
            int   guard = 0;
            logic rdy;
            while (!taken && guard < 200) begin
                @(negedge clk);
                if ($urandom_range(99, 0) < idle_pct) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_data  = stream[i];
                end
                rdy = a_in_ready;
                @(posedge clk);
                taken = in_valid && rdy;
                guard++;
            end
            if (!taken) chk({tag, "_handshake_timeout"}, 32'(taken), 32'd1);
        end
    endtask

    // Image model: length header decides the outcome, payload gives the write list.
    task automatic finish_check(input string tag);
        int n;
        n = int'({stream[0], stream[1]});
        if (n >= 1 && n <= 1024) begin
            for (int i = 0; i < n; i++) begin
                logic [15:0] w;
                w = {stream[2 + 2*i], stream[3 + 2*i]};
                exp_a.push_back({16'(2*i), w});
                exp_b.push_back({16'(32'hFFFE + 2*i), w});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (n >= 1 && n <= 1024) begin
            chk({tag, "_last_strobe"}, 32'(a_mem_write), 32'd1);
            chk({tag, "_not_done_yet"}, 32'(a_done), 32'd0);
            @(negedge clk);
        end
        if (n > 1024) check_status({tag, "_end"}, 1'b0, 1'b1, 1'b0, 1'b0);
        else          check_status({tag, "_end"}, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            chk({tag, "_refuse_ready"}, 32'(a_in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_a_nwr"}, 32'(wr_a.size()), 32'(exp_a.size()));
        chk({tag, "_b_nwr"}, 32'(wr_b.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_a.size() && i < wr_a.size(); i++)
            chk($sformatf("%s_a_wr%0d", tag, i), wr_a[i], exp_a[i]);
        for (int i = 0; i < exp_b.size() && i < wr_b.size(); i++)
            chk($sformatf("%s_b_wr%0d", tag, i), wr_b[i], exp_b[i]);
    endtask

    task automatic random_image(input int n_words);
        stream.delete();
        stream.push_back(8'(n_words >> 8));
        stream.push_back(8'(n_words));
        for (int i = 0; i < 2*n_words; i++) stream.push_back(8'($urandom));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);

        do_reset("t1"); clear_queues();
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_stream(0, "t1"); finish_check("t1");

        do_reset("t2"); clear_queues();
        stream = '{8'h00, 8'h00};
        send_stream(0, "t2"); finish_check("t2");

        do_reset("t3"); clear_queues();
        stream = '{8'h04, 8'h01};
        send_stream(0, "t3"); finish_check("t3");

        do_reset("t4"); clear_queues();
        random_image(3);
        send_stream(50, "t4"); finish_check("t4");

        // Reset after the first of three words, then reload a 1-word image.
        do_reset("t5"); clear_queues();
        random_image(3);
        stream = stream[0:3];
        send_stream(0, "t5a");
        @(negedge clk);
        in_valid = 1'b0;
        exp_a.push_back({16'h0000, stream[2], stream[3]});
        exp_b.push_back({16'hFFFE, stream[2], stream[3]});
        do_reset("t5b");
        stream = '{8'h00, 8'h01, 8'h55, 8'hAA};
        send_stream(0, "t5c"); finish_check("t5c");

        do_reset("t6"); clear_queues();
        random_image(2);
        send_stream(30, "t6"); finish_check("t6");

        do_reset("t7"); clear_queues();
        random_image(1024);
        send_stream(0, "t7"); finish_check("t7");

        for (int r = 0; r < 4; r++) begin
            do_reset($sformatf("r%0d", r)); clear_queues();
            random_image(int'($urandom_range(6, 1)));
            send_stream(int'($urandom_range(60, 0)), $sformatf("r%0d", r));
            finish_check($sformatf("r%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
